// File: rtl/sweep_seq.sv
// Sweeps a 4-input AND stage through all 16 input vectors, holding each for HOLD
// cycles, capturing the result of each vector and counting outputs that are not a true AND.
module sweep_seq #(
  parameter int unsigned HOLD = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_out,
  output logic        m,
  output logic        n,
  output logic        p,
  output logic        q,
  output logic        busy,
  output logic        done,
  output logic [3:0]  index,
  output logic [15:0] truth_tbl,
  output logic [4:0]  err_cnt
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  hold_cnt, hold_nxt;
  logic [3:0]     index_nxt;
  logic [3:0]     pat, pat_nxt;
  logic           busy_nxt, done_nxt;
  logic [15:0]    tbl_nxt;
  logic [4:0]     err_nxt;

  assign {m, n, p, q} = pat;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      index     <= '0;
      pat       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth_tbl <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      index     <= index_nxt;
      pat       <= pat_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      truth_tbl <= tbl_nxt;
      err_cnt   <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    index_nxt = index;
    pat_nxt   = pat;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    tbl_nxt   = truth_tbl;
    err_nxt   = err_cnt;
    case (state)
      IDLE: begin
        pat_nxt = 4'h0;
        if (start) begin
          state_nxt = DRIVE;
          hold_nxt  = '0;
          index_nxt = 4'h0;
          busy_nxt  = 1'b1;
          tbl_nxt   = '0;
          err_nxt   = '0;
        end
      end
      DRIVE: begin
        if (hold_cnt == LAST) begin
          // Sample on the last hold cycle so dut_out has settled
          tbl_nxt[index] = dut_out;
          if (dut_out != (index == 4'hF)) err_nxt = err_cnt + 5'd1;
          if (index != 4'hF) begin
            index_nxt = index + 4'd1;
            pat_nxt   = index + 4'd1;
            hold_nxt  = '0;
          end else begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          hold_nxt = hold_cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        pat_nxt   = 4'h0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        pat_nxt   = 4'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_sweep_seq.sv
// Bench for sweep_seq: cycle-level sweep model checked every cycle, plus directed
// scenarios with literal expectations for each sweep result.
module tb_sweep_seq;

  localparam int unsigned HOLD = 19;
  localparam int SWEEP = 16 * HOLD;

  logic        clk = 1'b0;
  logic        rst_n, start, dut_out;
  logic        m, n, p, q, busy, done;
  logic [3:0]  index;
  logic [15:0] truth_tbl;
  logic [4:0]  err_cnt;

  int mode;      // 0: real AND stage, 1: stuck at 0, 2: stuck at 1
  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;

  sweep_seq #(.HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .m(m), .n(n), .p(p), .q(q), .busy(busy), .done(done),
    .index(index), .truth_tbl(truth_tbl), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign dut_out = (mode == 0) ? (m & n & p & q) : (mode == 2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sweep is a run of 16*HOLD cycles; cycle t drives pattern t/HOLD
  int          mph = 0;  // 0 idle, 1 sweeping, 2 completion cycle
  int          mt = 0;
  int          midx = 0;
  int          merr = 0;
  logic [15:0] mtbl = '0;

  always @(posedge clk) begin
    int pat_i;
    logic v;
    if (!rst_n) begin
      mph = 0; mt = 0; midx = 0; merr = 0; mtbl = '0;
    end else begin
      case (mph)
        0: if (start) begin
          mph = 1; mt = 0; midx = 0; merr = 0; mtbl = '0;
        end
        1: begin
          pat_i = mt / HOLD;
          v = (mode == 0) ? (pat_i == 15) : (mode == 2);
          if (mt % HOLD == HOLD - 1) begin
            mtbl[pat_i] = v;
            if (v != (pat_i == 15)) merr++;
          end
          mt++;
          if (mt == SWEEP) mph = 2;
          else midx = mt / HOLD;
        end
        default: mph = 0;
      endcase
    end
  end

  // Compare every cycle shortly after the edge
  always @(posedge clk) begin
    #1;
    chk("busy", 32'(busy), 32'(mph == 1));
    chk("done", 32'(done), 32'(mph == 2));
    chk("index", 32'(index), 32'(midx));
    chk("truth_tbl", 32'(truth_tbl), 32'(mtbl));
    chk("err_cnt", 32'(err_cnt), 32'(merr));
    if (mph != 2)
      chk("mnpq", 32'({m, n, p, q}), (mph == 1) ? 32'(midx) : 32'd0);
    if (done) done_seen++;
  end

  // Called on the negedge of the first busy cycle; returns at the first non-busy negedge
  task automatic run_busy(input int pulse_at, input bit keep_start, output int len);
    len = 0;
    while (busy && len < SWEEP + 50) begin
      len++;
      if (!keep_start) start = (len == pulse_at);
      @(negedge clk);
    end
    if (!keep_start) start = 1'b0;
  endtask

  task automatic finish_chk(input string nm, input int len, input logic [15:0] tbl,
                            input logic [4:0] err);
    chk({nm, "_len"}, 32'(len), 32'(SWEEP));
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_tbl"}, 32'(truth_tbl), 32'(tbl));
    chk({nm, "_err"}, 32'(err_cnt), 32'(err));
    chk({nm, "_idx"}, 32'(index), 32'd15);
  endtask

  task automatic do_sweep(input string nm, input int md, input logic [15:0] tbl,
                          input logic [4:0] err);
    int len;
    mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_start"}, 32'(busy), 32'd1);
    run_busy(0, 1'b0, len);
    finish_chk(nm, len, tbl, err);
    @(negedge clk);
  endtask

  initial begin
    int len, d0;
    mode = 0; start = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tbl", 32'(truth_tbl), 32'd0);
    chk("rst_idx", 32'(index), 32'd0);

    // Start accepted on the first edge out of reset; correct AND stage
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_start", 32'(busy), 32'd1);
    run_busy(0, 1'b0, len);
    finish_chk("and", len, 16'h8000, 5'd0);
    @(negedge clk);
    chk("and_hold_tbl", 32'(truth_tbl), 32'h8000);
    chk("idle_mnpq", 32'({m, n, p, q}), 32'd0);

    do_sweep("stuck0", 1, 16'h0000, 5'd1);
    do_sweep("stuck1", 2, 16'hFFFF, 5'd15);

    // Start pulses during busy and during DONE are ignored
    mode = 0;
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_busy(50, 1'b0, len);
    finish_chk("ign", len, 16'h8000, 5'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ign_no_restart", 32'(busy), 32'd0);
    chk("ign_one_done", 32'(done_seen - d0), 32'd1);

    // Reset mid-sweep leaves nothing behind
    mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 100; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tbl", 32'(truth_tbl), 32'd0);
    chk("abort_err", 32'(err_cnt), 32'd0);
    chk("abort_idx", 32'(index), 32'd0);
    chk("abort_mnpq", 32'({m, n, p, q}), 32'd0);
    @(negedge clk);
    do_sweep("after_abort", 0, 16'h8000, 5'd0);

    // Start held high: back-to-back sweeps, one DONE and one IDLE cycle apart
    mode = 2;
    start = 1'b1;
    @(negedge clk);
    run_busy(0, 1'b1, len);
    finish_chk("b2b1", len, 16'hFFFF, 5'd15);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_tbl", 32'(truth_tbl), 32'hFFFF);
    @(negedge clk);
    chk("b2b_restart", 32'(busy), 32'd1);
    chk("b2b_cleared", 32'(truth_tbl), 32'd0);
    mode = 0;
    run_busy(0, 1'b1, len);
    start = 1'b0;
    finish_chk("b2b2", len, 16'h8000, 5'd0);
    repeat (4) @(negedge clk);
    chk("end_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
